// File: rtl/irq_gather_16.sv
// rtl/irq_gather_16.sv - 16-line interrupt gatherer with sync, edge/level pending and priority encode
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   IN0..IN15         discrete event lines, may be asynchronous to clk
//   irq_mask[15:0]    per-line enable onto dout/irq_req
//   irq_ack, ack_id   one-cycle ack strobe and the line index it clears
//   dout[15:0]        pending & mask, bit k = INk
//   pend_raw[15:0]    pending register before masking
//   irq_req           any bit of dout set
//   irq_id[3:0]       lowest-numbered set bit of dout, 0 when none

module irq_gather_16 #(
    parameter int          SIGNAL_IN_NUM = 16,
    parameter int          SYNC_STAGES   = 2,
    parameter logic [15:0] EDGE_MASK     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IN0,
    input  logic        IN1,
    input  logic        IN2,
    input  logic        IN3,
    input  logic        IN4,
    input  logic        IN5,
    input  logic        IN6,
    input  logic        IN7,
    input  logic        IN8,
    input  logic        IN9,
    input  logic        IN10,
    input  logic        IN11,
    input  logic        IN12,
    input  logic        IN13,
    input  logic        IN14,
    input  logic        IN15,
    input  logic [15:0] irq_mask,
    input  logic        irq_ack,
    input  logic [3:0]  ack_id,
    output logic [15:0] dout,
    output logic [15:0] pend_raw,
    output logic        irq_req,
    output logic [3:0]  irq_id
);

    if (SIGNAL_IN_NUM != 16) begin : g_bad_num
        $error("irq_gather_16: SIGNAL_IN_NUM must be 16");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("irq_gather_16: SYNC_STAGES must be 0..3");
    end

    logic [15:0] in_vec;
    logic [15:0] s;
    logic [15:0] prev_q;
    logic [15:0] pend_q;
    logic [15:0] pend_d;
    logic [15:0] rise;
    logic [15:0] clr;

    assign in_vec = {IN15, IN14, IN13, IN12, IN11, IN10, IN9, IN8,
                     IN7,  IN6,  IN5,  IN4,  IN3,  IN2,  IN1, IN0};

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = in_vec;
    end else begin : g_sync
        logic [15:0] sync_q [SYNC_STAGES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= '0;
                end
            end else begin
                sync_q[0] <= in_vec;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign s = sync_q[SYNC_STAGES-1];
    end

    assign rise = s & ~prev_q;
    assign clr  = irq_ack ? (16'h0001 << ack_id) : 16'h0000;

    // Edge lines: the rise term is OR-ed after the clear so a rise coinciding
    // with an ack of the same bit keeps the bit pending. Level lines ignore ack.
    always_comb begin
        pend_d = (EDGE_MASK & ((pend_q & ~clr) | rise)) | (~EDGE_MASK & s);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= s;
            pend_q <= pend_d;
        end
    end

    assign pend_raw = pend_q;
    assign dout     = pend_q & irq_mask;
    assign irq_req  = |dout;

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        irq_id = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (dout[k]) begin
                irq_id = 4'(k);
            end
        end
    end

endmodule

// File: tb/tb_irq_gather_16.sv
// tb/tb_irq_gather_16.sv - directed bench for irq_gather_16

module tb_irq_gather_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_vec;
    logic [15:0] irq_mask;
    logic        irq_ack;
    logic [3:0]  ack_id;
    logic [15:0] dout;
    logic [15:0] pend_raw;
    logic        irq_req;
    logic [3:0]  irq_id;

    int n_checks;
    int n_errors;

    irq_gather_16 #(
        .SIGNAL_IN_NUM(16),
        .SYNC_STAGES  (2),
        .EDGE_MASK    (16'hFFFB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .IN0     (in_vec[0]),
        .IN1     (in_vec[1]),
        .IN2     (in_vec[2]),
        .IN3     (in_vec[3]),
        .IN4     (in_vec[4]),
        .IN5     (in_vec[5]),
        .IN6     (in_vec[6]),
        .IN7     (in_vec[7]),
        .IN8     (in_vec[8]),
        .IN9     (in_vec[9]),
        .IN10    (in_vec[10]),
        .IN11    (in_vec[11]),
        .IN12    (in_vec[12]),
        .IN13    (in_vec[13]),
        .IN14    (in_vec[14]),
        .IN15    (in_vec[15]),
        .irq_mask(irq_mask),
        .irq_ack (irq_ack),
        .ack_id  (ack_id),
        .dout    (dout),
        .pend_raw(pend_raw),
        .irq_req (irq_req),
        .irq_id  (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack(input logic [3:0] id);
        irq_ack = 1'b1;
        ack_id  = id;
        step(1);
        irq_ack = 1'b0;
        ack_id  = 4'd0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        in_vec   = 16'hFFFF;
        irq_mask = 16'hFFFF;
        irq_ack  = 1'b0;
        ack_id   = 4'd0;

        // 1. reset holds everything clear even with all inputs high
        #1;
        for (int c = 0; c < 5; c++) begin
            check("rst_dout", dout, 16'h0000);
            check("rst_req", {15'd0, irq_req}, 16'h0000);
            check("rst_id", {12'd0, irq_id}, 16'h0000);
            step(1);
        end
        check("rst_pend", pend_raw, 16'h0000);
        in_vec = 16'h0000;
        step(3);
        rst_n = 1'b1;
        step(4);
        check("post_rst_pend", pend_raw, 16'h0000);

        // 2. latency of a one-cycle pulse on IN5
        in_vec[5] = 1'b1;
        step(1);
        in_vec[5] = 1'b0;
        step(1);
        check("lat_edge2", pend_raw, 16'h0000);
        step(1);
        check("lat_edge3", pend_raw, 16'h0020);
        check("lat_id", {12'd0, irq_id}, 16'd5);
        step(4);
        check("lat_sticky", pend_raw, 16'h0020);
        ack(4'd5);
        check("lat_acked", pend_raw, 16'h0000);

        // 3. priority and ack sequencing, inputs held high
        in_vec[3] = 1'b1;
        in_vec[9] = 1'b1;
        step(3);
        check("pri_dout", dout, 16'h0208);
        check("pri_id3", {12'd0, irq_id}, 16'd3);
        ack(4'd3);
        check("pri_dout9", dout, 16'h0200);
        check("pri_id9", {12'd0, irq_id}, 16'd9);
        ack(4'd9);
        check("pri_req0", {15'd0, irq_req}, 16'h0000);
        ack(4'd4);
        step(4);
        check("pri_held_no_retrig", pend_raw, 16'h0000);
        in_vec[3] = 1'b0;
        in_vec[9] = 1'b0;
        step(4);

        // 4. rise and ack of the same bit in one cycle: rise wins
        in_vec[7] = 1'b1;
        step(1);
        in_vec[7] = 1'b0;
        step(5);
        check("col_pre", pend_raw, 16'h0080);
        in_vec[7] = 1'b1;
        step(2);
        ack(4'd7);
        check("col_kept", pend_raw, 16'h0080);
        ack(4'd7);
        check("col_cleared", pend_raw, 16'h0000);
        in_vec[7] = 1'b0;
        step(3);

        // masked edge line still latches; unmask raises irq the same cycle
        irq_mask = 16'h0000;
        in_vec[12] = 1'b1;
        step(1);
        in_vec[12] = 1'b0;
        step(4);
        check("msk_pend", pend_raw, 16'h1000);
        check("msk_req0", {15'd0, irq_req}, 16'h0000);
        irq_mask = 16'hFFFF;
        #1;
        check("msk_req1", {15'd0, irq_req}, 16'h0001);
        check("msk_id", {12'd0, irq_id}, 16'd12);
        irq_mask = 16'h0000;
        ack(4'd12);
        check("msk_ack_masked", pend_raw, 16'h0000);
        irq_mask = 16'hFFFF;

        // 5. level line IN2
        irq_mask = 16'hFFFB;
        in_vec[2] = 1'b1;
        step(3);
        check("lvl_pend", pend_raw, 16'h0004);
        check("lvl_dout", dout, 16'h0000);
        irq_mask = 16'hFFFF;
        #1;
        check("lvl_id", {12'd0, irq_id}, 16'd2);
        ack(4'd2);
        check("lvl_ack_noop", pend_raw, 16'h0004);
        in_vec[2] = 1'b0;
        step(2);
        check("lvl_fall2", pend_raw, 16'h0004);
        step(1);
        check("lvl_fall3", pend_raw, 16'h0000);

        // 6. mid-operation reset
        in_vec[0]  = 1'b1;
        in_vec[15] = 1'b1;
        step(1);
        in_vec[0]  = 1'b0;
        in_vec[15] = 1'b0;
        step(4);
        check("mrst_pre", pend_raw, 16'h8001);
        in_vec[1] = 1'b1;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_async", pend_raw, 16'h0000);
        check("mrst_req", {15'd0, irq_req}, 16'h0000);
        in_vec[1] = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(5);
        check("mrst_after", pend_raw, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
